// File: rtl/saturate_pipe_if.sv
// Bundles the sample stream and statistics outputs of the saturation stage.
// The master modport belongs to whoever supplies samples and consumes the
// clamped results; the slave modport is the saturation stage itself.
interface saturate_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 10,
  parameter int CNT_W = 8
);
  logic             in_vld;
  logic [IN_W-1:0]  in_data;
  logic             clr_stat;
  logic             out_vld;
  logic [OUT_W-1:0] out_data;
  logic             sat_hi;
  logic             sat_lo;
  logic             sat_sticky;
  logic [CNT_W-1:0] sat_cnt;
  logic             windup;

  modport master (
    output in_vld, in_data, clr_stat,
    input  out_vld, out_data, sat_hi, sat_lo, sat_sticky, sat_cnt, windup
  );

  modport slave (
    input  in_vld, in_data, clr_stat,
    output out_vld, out_data, sat_hi, sat_lo, sat_sticky, sat_cnt, windup
  );
endinterface

// File: rtl/saturate_pipe.sv
// Registered saturation stage: clamps a wide error term to OUT_W bits with one
// cycle of latency, and tracks saturation statistics plus a windup detector
// that tells the PID integrator when to freeze.
module saturate_pipe #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 10,
  parameter int SIGNED    = 1,
  parameter int CNT_W     = 8,
  parameter int WINDUP_TH = 4
) (
  input  logic            clk,
  input  logic            rst,
  saturate_pipe_if.slave  bus
);

  typedef enum logic [1:0] {
    NORM = 2'd0,
    RUN  = 2'd1,
    WIND = 2'd2
  } wind_state_t;

  localparam logic [7:0]       TH_8    = 8'(WINDUP_TH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Clamp result for the sample currently on the input
  logic [OUT_W-1:0] clamp_data;
  logic             clamp_hi;
  logic             clamp_lo;
  logic             clamp_sat;

  // Output and statistics registers
  logic             out_vld_reg;
  logic [OUT_W-1:0] out_data_reg;
  logic             sat_hi_reg;
  logic             sat_lo_reg;
  logic             sat_sticky_reg;
  logic [CNT_W-1:0] sat_cnt_reg;

  // Windup tracker; dir is 1 for high-side saturation, 0 for low-side
  wind_state_t state_reg, state_next;
  logic [7:0]  run_reg, run_next;
  logic        dir_reg, dir_next;

  // Clamp the incoming sample; signed mode requires the bits above the kept
  // sign bit to be a pure sign extension, unsigned mode requires them all zero
  always_comb begin
    clamp_data = bus.in_data[OUT_W-1:0];
    clamp_hi   = 1'b0;
    clamp_lo   = 1'b0;
    if (SIGNED != 0) begin
      if (!(&bus.in_data[IN_W-1:OUT_W-1]) && (|bus.in_data[IN_W-1:OUT_W-1])) begin
        if (bus.in_data[IN_W-1]) begin
          clamp_data = {1'b1, {(OUT_W-1){1'b0}}};
          clamp_lo   = 1'b1;
        end else begin
          clamp_data = {1'b0, {(OUT_W-1){1'b1}}};
          clamp_hi   = 1'b1;
        end
      end
    end else if (|bus.in_data[IN_W-1:OUT_W]) begin
      clamp_data = {OUT_W{1'b1}};
      clamp_hi   = 1'b1;
    end
  end

  assign clamp_sat = clamp_hi | clamp_lo;

  // Output stage: capture valid samples, hold data and flags across gaps
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_reg  <= 1'b0;
      out_data_reg <= '0;
      sat_hi_reg   <= 1'b0;
      sat_lo_reg   <= 1'b0;
    end else begin
      out_vld_reg <= bus.in_vld;
      if (bus.in_vld) begin
        out_data_reg <= clamp_data;
        sat_hi_reg   <= clamp_hi;
        sat_lo_reg   <= clamp_lo;
      end
    end
  end

  // Sticky flag and saturating event counter; a clear wins over a
  // same-cycle sample, which is then not counted
  always_ff @(posedge clk) begin
    if (rst || bus.clr_stat) begin
      sat_sticky_reg <= 1'b0;
      sat_cnt_reg    <= '0;
    end else if (bus.in_vld && clamp_sat) begin
      sat_sticky_reg <= 1'b1;
      if (sat_cnt_reg != CNT_MAX) begin
        sat_cnt_reg <= sat_cnt_reg + 1'b1;
      end
    end
  end

  // Windup tracker state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= NORM;
      run_reg   <= '0;
      dir_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      run_reg   <= run_next;
      dir_reg   <= dir_next;
    end
  end

  // Windup tracker next state: counts consecutive same-direction saturations;
  // idle cycles (in_vld=0) leave the run untouched
  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    dir_next   = dir_reg;
    if (bus.clr_stat) begin
      state_next = NORM;
      run_next   = '0;
    end else if (bus.in_vld) begin
      unique case (state_reg)
        NORM: begin
          if (clamp_sat) begin
            run_next   = 8'd1;
            dir_next   = clamp_hi;
            state_next = (WINDUP_TH == 1) ? WIND : RUN;
          end
        end
        RUN: begin
          if (!clamp_sat) begin
            state_next = NORM;
            run_next   = '0;
          end else if (clamp_hi == dir_reg) begin
            run_next = run_reg + 8'd1;
            if ((run_reg + 8'd1) >= TH_8) begin
              state_next = WIND;
            end
          end else begin
            run_next = 8'd1;
            dir_next = clamp_hi;
          end
        end
        WIND: begin
          if (!clamp_sat) begin
            state_next = NORM;
            run_next   = '0;
          end else if (clamp_hi != dir_reg) begin
            run_next   = 8'd1;
            dir_next   = clamp_hi;
            state_next = RUN;
          end
        end
        default: begin
          state_next = NORM;
          run_next   = '0;
        end
      endcase
    end
  end

  assign bus.out_vld    = out_vld_reg;
  assign bus.out_data   = out_data_reg;
  assign bus.sat_hi     = sat_hi_reg;
  assign bus.sat_lo     = sat_lo_reg;
  assign bus.sat_sticky = sat_sticky_reg;
  assign bus.sat_cnt    = sat_cnt_reg;
  assign bus.windup     = (state_reg == WIND);

endmodule

// File: doc/saturate_pipe.md
# saturate_pipe

Parametrised, registered saturation stage for the balance-control datapath. It clamps a wide signed or unsigned error term to a narrower width with one cycle of latency and a valid handshake. It also keeps saturation statistics: per-sample direction flags, a sticky flag, a saturating event counter, and a windup detector that flags N consecutive same-direction saturations so the PID integrator can freeze. It sits between the error/derivative arithmetic and the PID term multipliers, and replaces the fixed-width combinational saturators.

## Interface
- IN_W, 16, input data width; must satisfy IN_W > OUT_W.
- OUT_W, 10, output data width; OUT_W >= 2.
- SIGNED, 1, 1 = two's-complement clamp, 0 = unsigned clamp.
- CNT_W, 8, width of the saturation event counter.
- WINDUP_TH, 4, consecutive same-direction saturations that assert windup; range 1..255.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_vld  in  1  in_data is valid this cycle.
- in_data  in  IN_W  value to clamp, interpreted per SIGNED.
- clr_stat  in  1  synchronous clear of sat_sticky, sat_cnt and the windup tracker.
- out_vld  out  1  out_data and the per-sample flags are valid.
- out_data  out  OUT_W  clamped result.
- sat_hi  out  1  the sample was clamped at the maximum.
- sat_lo  out  1  the sample was clamped at the minimum; always 0 when SIGNED=0.
- sat_sticky  out  1  at least one saturation since the last reset or clear.
- sat_cnt  out  CNT_W  count of saturated samples; holds at all-ones instead of wrapping.
- windup  out  1  the windup tracker is in state WIND.

## Operation
- Clamp rules, unsigned (SIGNED=0):
  - If any of in_data[IN_W-1:OUT_W] is 1, output is all ones and sat_hi=1.
  - Otherwise output is in_data[OUT_W-1:0].
- Clamp rules, signed (SIGNED=1):
  - Let the upper field be in_data[IN_W-1:OUT_W-1].
  - Upper field all zeros or all ones: pass in_data[OUT_W-1:0].
  - Otherwise, if the MSB is 0: output is 0 followed by all ones (max positive) and sat_hi=1.
  - Otherwise, if the MSB is 1: output is 1 followed by all zeros (min negative) and sat_lo=1.
- sat_hi and sat_lo are never both 1.
- Statistics and the windup tracker update only on cycles with in_vld=1.
- sat_cnt increments by 1 on each saturated valid sample and holds at 2^CNT_W-1.
- sat_sticky is set on any saturated valid sample.
- Windup tracker state: state ∈ {NORM, RUN, WIND}, plus an 8-bit run count and a direction bit dir.
  - NORM: saturated sample → run=1, dir=the sample's direction, go to RUN. If WINDUP_TH=1, go directly to WIND.
  - RUN, same-direction saturated sample: run+1; go to WIND when run+1 reaches WINDUP_TH.
  - RUN, opposite-direction saturated sample: run=1, dir=new direction, stay in RUN.
  - RUN, unsaturated sample: go to NORM and set run=0.
  - WIND, same-direction saturated sample: stay in WIND.
  - WIND, opposite-direction saturated sample: run=1, dir=new direction, go to RUN.
  - WIND, unsaturated sample: go to NORM.
  - Any state with in_vld=0: no change.
- clr_stat=1: sat_sticky=0, sat_cnt=0, state=NORM, run=0.
  - clr_stat has priority over a same-cycle valid sample's statistics.
  - That sample is still clamped and output, and its sat_hi/sat_lo are still reported.
  - It is not counted, and it does not enter the tracker.

## Timing
- Latency: a sample presented with in_vld at edge k appears on out_data/out_vld/sat_hi/sat_lo after edge k.
- out_vld is a registered copy of in_vld. There is no backpressure; a new sample is accepted every cycle.
- When out_vld=0, out_data, sat_hi and sat_lo hold their previous values.
- sat_cnt, sat_sticky and windup reflect all samples up to and including the one currently on out_data; they update on the same edge.
- Reset values: out_vld=0, out_data=0, sat_hi=0, sat_lo=0, sat_sticky=0, sat_cnt=0, windup=0, state=NORM.
- rst asserted mid-stream discards the sample in flight; the first valid output after release comes from a sample taken after release.
- rst has priority over clr_stat and in_vld.

## Test plan
Unless noted, parameters are IN_W=16, OUT_W=10, SIGNED=1, WINDUP_TH=4, CNT_W=8.

- Signed clamp:
  - 0xFF4C → out_data=0x34C, flags 0.
  - 0xDF4C → 0x200 with sat_lo=1.
  - 0x004C → 0x04C.
  - 0x3F4C → 0x1FF with sat_hi=1.
  - Each result appears one cycle after in_vld; sat_cnt=2 after the sequence.
- Unsigned (SIGNED=0): 0x004C → 0x04C, flags 0; 0xFF4C → 0x3FF, sat_hi=1, sat_lo=0.
- Windup:
  - Four consecutive 0x3F4C samples → windup=1 with the 4th output.
  - Then 0xDF4C → windup=0 (tracker in RUN, dir low).
  - Then 0x0010 → state NORM, windup=0.
  - Gaps with in_vld=0 between samples do not break the run.
- Counter saturation: CNT_W=3 with 10 saturated samples → sat_cnt holds at 7.
- clr_stat together with a saturated sample:
  - out_data is clamped and sat_hi=1.
  - sat_cnt=0, sat_sticky=0, windup=0 afterwards.
- Reset:
  - Assert rst while windup=1 and sat_cnt=5 → all outputs 0 on the next cycle.
  - A sample held on in_vld during rst produces no output.
